mode_pattern_sequencer: RTL and testbench
=========================================

# mode_pattern_sequencer

Sequences the 8-LED display pattern for the four-mode, pause-capable board design. It sits downstream of the switch-mode register and consumes its 2-bit `mode` plus a debounced pause pulse. It divides the system clock into step ticks, advances a 3-bit pattern step while running, and freezes while paused. A mode change restarts the pattern cleanly from step 0.

## Interface
- `TICK_DIV`, default 25_000_000, clk cycles per pattern step; legal range ≥ 2. Benches use 4.
- `clk` input 1: system clock, rising-edge.
- `reset` input 1: asynchronous, active-high.
- `mode_in` input 2: requested mode, already clk-synchronous. 00 = MODE1, 01 = MODE2, 10 = MODE3, 11 = MODE4.
- `pause_btn` input 1: debounced, clk-synchronous single-cycle pulse; each pulse toggles run/pause.
- `led` output 8: registered LED pattern.
- `running` output 1: 1 in RUN, 0 in PAUSE.
- `active_mode` output 2: mode currently being displayed.
- `step` output 3: current pattern step, 0..7.
- `tick` output 1: single-cycle pulse, high in the cycle after `step` advanced.

## Operation
- State machine, 2 states:
  - RUN → PAUSE on `pause_btn`.
  - PAUSE → RUN on `pause_btn`.
  - No other transitions.
- Prescaler `cnt` (width clog2(TICK_DIV)):
  - In RUN: counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0, `step` increments mod 8 (7 → 0), and `tick` asserts next cycle.
  - In PAUSE: `cnt` and `step` hold; `tick` stays 0.
- Mode change. Any cycle where `mode_in != active_mode`, next edge:
  - `active_mode <= mode_in`, `step <= 0`, `cnt <= 0`, no tick.
  - Run/pause state is unchanged, so a change while paused shows step 0 of the new mode, frozen.
- Pattern, as a function of (`active_mode`, `step` = s):
  - 00: 8'h01 << s, i.e. 01, 02, … 80, wrap.
  - 01: 8'h80 >> s, i.e. 80, 40, … 01, wrap.
  - 10: fill bar (8'h02 << s) - 1, i.e. 01, 03, 07, … FF, wrap to 01. Compute in 9 bits and truncate.
  - 11: alternate; s[0]=0 → 8'hAA, s[0]=1 → 8'h55.
- `led` is registered from the registered `active_mode`/`step`.
- Simultaneous events, same cycle:
  - `pause_btn` + prescaler terminal count in RUN: the step advance still happens; PAUSE takes effect from the next cycle.
  - Mode change + terminal count: the mode change wins; `step` = 0, no tick.
  - Mode change + `pause_btn`: both apply.
- Reset, asynchronous, at any time including mid-step: immediately forces all state to reset values. No partial pattern survives.

## Timing
- Reset values:
  - state RUN, `running` = 1
  - `active_mode` = 00, `step` = 0, `cnt` = 0
  - `tick` = 0, `led` = 8'h01
- Step period in RUN is exactly TICK_DIV cycles. After reset release, the first advance happens on the TICK_DIV-th rising edge.
- `step`, `active_mode` and `running` update on the edge following the causing input.
- `led` lags `step`/`active_mode` by exactly 1 cycle. `tick` is aligned with `led` showing the new step.
- Pause latency: `running` falls 1 cycle after the `pause_btn` cycle. Resume continues from the held `cnt`, so the interrupted step keeps its remaining count.
- `pause_btn` held high for N cycles counts as N toggles. The upstream debouncer guarantees a single-cycle pulse.

## Test plan
- Reset, `mode_in` = 00, TICK_DIV = 4, run 40 cycles:
  - `led` = 01, 02, 04, … 80, 01, changing every 4 cycles.
  - `tick` high 1 cycle per change.
- `mode_in` = 10 from step 0, run 36 cycles:
  - `led` = 01, 03, 07, 0F, 1F, 3F, 7F, FF, then wraps to 01.
- `pause_btn` pulse at step 3, wait 20 cycles, pulse again:
  - `running` = 0 from the next cycle; `led` frozen at 08 (mode 00) for the whole pause.
  - After resume, step 4 appears after the residual count, not before.
- `mode_in` 00 → 11 mid-step (`cnt` = 2):
  - Next cycle: `step` = 0, `active_mode` = 11.
  - The cycle after: `led` = AA.
  - 4 cycles later: `led` = 55.
- `mode_in` change in the same cycle as terminal count, and separately `pause_btn` at terminal count:
  - First case: `step` = 0, no `tick`.
  - Second case: `step` advances, then holds with `running` = 0.
- Assert `reset` asynchronously mid-step while paused in mode 01:
  - Outputs return immediately to `led` = 01, `running` = 1, `step` = 0, `active_mode` = 00, without waiting for a clk edge.

Source files
------------

// File: rtl/mode_pattern_sequencer.sv
// LED pattern sequencer: prescaled step counter with run/pause control and
// four display modes; a mode change restarts the pattern from step 0.
module mode_pattern_sequencer #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode_in,
  input  logic       pause_btn,
  output logic [7:0] led,
  output logic       running,
  output logic [1:0] active_mode,
  output logic [2:0] step,
  output logic       tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  step_q, step_d;
  logic [1:0]  mode_q, mode_d;
  logic        adv_q, adv_d;
  logic [7:0]  led_q;
  logic        tick_q;
  logic        mode_chg_s;
  logic        terminal_s;

  function automatic logic [7:0] pattern(input logic [1:0] m, input logic [2:0] s);
    logic [7:0] p;
    case (m)
      2'b00:   p = 8'h01 << s;
      2'b01:   p = 8'h80 >> s;
      2'b10:   p = 8'((9'h002 << s) - 9'h001);
      2'b11:   p = s[0] ? 8'h55 : 8'hAA;
      default: p = 8'h01;
    endcase
    return p;
  endfunction

  assign mode_chg_s = (mode_in != mode_q);
  assign terminal_s = (state_q == ST_RUN) && (cnt_q == CW'(TICK_DIV - 1));

  // Next-state: mode change overrides the step advance; pause toggles independently.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    mode_d  = mode_q;
    adv_d   = 1'b0;
    if (pause_btn) begin
      state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
    end else begin
      state_d = state_q;
    end
    if (mode_chg_s) begin
      mode_d = mode_in;
      step_d = 3'd0;
      cnt_d  = '0;
    end else if (terminal_s) begin
      cnt_d  = '0;
      step_d = step_q + 3'd1;
      adv_d  = 1'b1;
    end else if (state_q == ST_RUN) begin
      cnt_d  = cnt_q + CW'(1);
    end else begin
      cnt_d  = cnt_q;
    end
  end

  // State, prescaler and output registers; tick follows the step advance
  // by one cycle so it lines up with led showing the new step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      step_q  <= 3'd0;
      mode_q  <= 2'b00;
      adv_q   <= 1'b0;
      led_q   <= 8'h01;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
      adv_q   <= adv_d;
      led_q   <= pattern(mode_q, step_q);
      tick_q  <= adv_q;
    end
  end

  assign led         = led_q;
  assign running     = (state_q == ST_RUN);
  assign active_mode = mode_q;
  assign step        = step_q;
  assign tick        = tick_q;

endmodule

// File: tb/tb_mode_pattern_sequencer.sv
// Self-checking bench: randomized and directed stimulus against a
// cycle-level behavioural model of the pattern sequencer.
module tb_mode_pattern_sequencer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode_in;
  logic       pause_btn;
  logic [7:0] led;
  logic       running;
  logic [1:0] active_mode;
  logic [2:0] step;
  logic       tick;

  int vectors = 0;
  int errors  = 0;

  // model state
  bit       m_run;
  bit [1:0] m_mode;
  int       m_step;
  int       m_el;
  bit [1:0] p_mode;
  int       p_step;
  bit       p_adv;
  bit [7:0] e_led;
  bit       e_tick;

  mode_pattern_sequencer #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .mode_in(mode_in), .pause_btn(pause_btn),
    .led(led), .running(running), .active_mode(active_mode), .step(step), .tick(tick)
  );

  always #5 clk = ~clk;

  function automatic bit [7:0] pat(input bit [1:0] m, input int s);
    int v;
    case (m)
      2'd0:    v = 1 << s;
      2'd1:    v = 128 >> s;
      2'd2:    v = ((2 << s) - 1) % 256;
      default: v = (s % 2 == 0) ? 170 : 85;
    endcase
    return v[7:0];
  endfunction

  task automatic model_reset();
    m_run = 1'b1; m_mode = 2'd0; m_step = 0; m_el = 0;
    p_mode = 2'd0; p_step = 0; p_adv = 1'b0;
    e_led = 8'h01; e_tick = 1'b0;
  endtask

  task automatic model_edge(input bit [1:0] m, input bit p);
    bit adv;
    adv = 1'b0;
    e_led  = pat(p_mode, p_step);
    e_tick = p_adv;
    if (m != m_mode) begin
      m_mode = m; m_step = 0; m_el = 0;
    end else if (m_run) begin
      m_el++;
      if (m_el == TD) begin
        m_el = 0; m_step = (m_step + 1) % 8; adv = 1'b1;
      end
    end
    if (p) m_run = !m_run;
    p_mode = m_mode; p_step = m_step; p_adv = adv;
  endtask

  task automatic check_all(input string tag);
    vectors++;
    if (led !== e_led || running !== m_run || active_mode !== m_mode ||
        step !== 3'(m_step) || tick !== e_tick) begin
      errors++;
      $display("FAIL %s t=%0t: led=%h run=%b mode=%0d step=%0d tick=%b | required led=%h run=%b mode=%0d step=%0d tick=%b",
               tag, $time, led, running, active_mode, step, tick,
               e_led, m_run, m_mode, m_step, e_tick);
    end
  endtask

  task automatic lit(input string tag, input int act, input int req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s t=%0t: got %0h required %0h", tag, $time, act, req);
    end
  endtask

  task automatic cyc(input bit [1:0] m, input bit p, input string tag);
    mode_in = m; pause_btn = p;
    @(posedge clk);
    model_edge(m, p);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    lit("rst_led", int'(led), 8'h01);
    lit("rst_run", int'(running), 1);
    lit("rst_step", int'(step), 0);
    lit("rst_mode", int'(active_mode), 0);
    lit("rst_tick", int'(tick), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // run in the given mode until the model reaches a condition, bounded
  task automatic run_until_step(input bit [1:0] m, input int s, input string tag);
    int g;
    g = 0;
    while (!(m_step == s && m_mode == m) && g < 200) begin
      cyc(m, 1'b0, tag);
      g++;
    end
    lit({tag, "_bound"}, int'(g < 200), 1);
  endtask

  task automatic run_until_terminal(input bit [1:0] m, input string tag);
    int g;
    g = 0;
    while (!(m_el == TD - 1 && m_run && m_mode == m) && g < 200) begin
      cyc(m, 1'b0, tag);
      g++;
    end
    lit({tag, "_bound"}, int'(g < 200), 1);
  endtask

  initial begin
    int s0;
    mode_in = 2'd0; pause_btn = 1'b0; reset = 1'b1;
    model_reset();
    #1;
    lit("init_led", int'(led), 8'h01);
    do_reset();

    // mode 00 walk: step 3 shown as 08 on the 13th edge
    for (int i = 1; i <= 40; i++) begin
      cyc(2'd0, 1'b0, "walk00");
      if (i == 4)  lit("first_adv_step", int'(step), 1);
      if (i == 5)  lit("first_tick", int'(tick), 1);
      if (i == 13) lit("walk00_led08", int'(led), 8'h08);
    end

    // fill bar from step 0
    cyc(2'd2, 1'b0, "fill_chg");
    lit("fill_step0", int'(step), 0);
    for (int i = 1; i <= 36; i++) begin
      cyc(2'd2, 1'b0, "fill");
      if (i == 1)  lit("fill_led01", int'(led), 8'h01);
      if (i == 29) lit("fill_ledFF", int'(led), 8'hFF);
      if (i == 33) lit("fill_wrap01", int'(led), 8'h01);
    end

    // pause at step 3 in mode 00
    do_reset();
    run_until_step(2'd0, 3, "to_s3");
    cyc(2'd0, 1'b0, "s3_show");
    cyc(2'd0, 1'b1, "pause");
    lit("pause_run", int'(running), 0);
    for (int i = 0; i < 20; i++) begin
      cyc(2'd0, 1'b0, "paused");
      lit("paused_led", int'(led), 8'h08);
    end
    cyc(2'd0, 1'b1, "resume");
    lit("resume_hold", int'(step), 3);
    cyc(2'd0, 1'b0, "resid1");
    lit("resid1_step", int'(step), 3);
    cyc(2'd0, 1'b0, "resid2");
    lit("resid2_step", int'(step), 4);

    // mode 00 -> 11 mid-step
    do_reset();
    cyc(2'd0, 1'b0, "mid0");
    cyc(2'd0, 1'b0, "mid1");
    cyc(2'd3, 1'b0, "to11");
    lit("to11_step", int'(step), 0);
    lit("to11_mode", int'(active_mode), 3);
    cyc(2'd3, 1'b0, "alt0");
    lit("alt_AA", int'(led), 8'hAA);
    for (int i = 0; i < 4; i++) cyc(2'd3, 1'b0, "alt");
    lit("alt_55", int'(led), 8'h55);

    // mode change at terminal count
    run_until_step(2'd3, 2, "to_s2");
    run_until_terminal(2'd3, "to_tc");
    cyc(2'd1, 1'b0, "chg_tc");
    lit("chg_tc_step", int'(step), 0);
    cyc(2'd1, 1'b0, "chg_tc2");
    cyc(2'd1, 1'b0, "chg_tc3");
    lit("chg_tc_notick", int'(tick), 0);

    // pause at terminal count
    run_until_terminal(2'd1, "to_tc2");
    s0 = m_step;
    cyc(2'd1, 1'b1, "pause_tc");
    lit("pause_tc_adv", int'(step), (s0 + 1) % 8);
    lit("pause_tc_run", int'(running), 0);
    for (int i = 0; i < 6; i++) cyc(2'd1, 1'b0, "pause_tc_hold");
    lit("pause_tc_held", int'(step), (s0 + 1) % 8);

    // async reset mid-step while paused in mode 01
    cyc(2'd1, 1'b0, "pre_rst");
    #2;
    do_reset();

    // randomized phase
    for (int i = 0; i < 1500; i++) begin
      bit [1:0] m;
      bit p;
      m = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : m_mode;
      p = ($urandom_range(0, 11) == 0);
      cyc(m, p, "rand");
      if ($urandom_range(0, 299) == 0) begin
        #2;
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
